// File: rtl/vga_scan_controller.sv
// VGA scan timing sequencer: pixel-tick divider, H/V scan counters, phase decode,
// sync/active/coordinate outputs, with frame-aligned start and stop.
module vga_scan_controller #(
    parameter int PIX_DIV    = 2,
    parameter int H_SYNC_END = 95,
    parameter int H_BP_END   = 143,
    parameter int H_ACT_END  = 783,
    parameter int H_TOTAL    = 800,
    parameter int V_SYNC_END = 1,
    parameter int V_BP_END   = 34,
    parameter int V_ACT_END  = 514,
    parameter int V_TOTAL    = 525
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    output logic       PIX_TICK,
    output logic [9:0] HCNT,
    output logic [9:0] VCNT,
    output logic [1:0] H_STATE,
    output logic [1:0] V_STATE,
    output logic       HS,
    output logic       VS,
    output logic       ACTIVE,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       LINE_START,
    output logic       FRAME_START,
    output logic       RUNNING
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_S0    = 10'(H_SYNC_END);
    localparam logic [9:0] H_S1    = 10'(H_BP_END);
    localparam logic [9:0] H_S2    = 10'(H_ACT_END);
    localparam logic [9:0] V_S0    = 10'(V_SYNC_END);
    localparam logic [9:0] V_S1    = 10'(V_BP_END);
    localparam logic [9:0] V_S2    = 10'(V_ACT_END);
    localparam logic [9:0] X_ORG   = 10'(H_BP_END + 1);
    localparam logic [9:0] Y_ORG   = 10'(V_BP_END + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [1:0]       h_state_q, h_state_d;
    logic [1:0]       v_state_q, v_state_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             active_q, active_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             pix_tick_q, pix_tick_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             running_q, running_d;

    function automatic logic [1:0] phase_of(input logic [9:0] cnt, input logic [9:0] e0,
                                            input logic [9:0] e1, input logic [9:0] e2);
        if (cnt <= e0)      phase_of = 2'd0;
        else if (cnt <= e1) phase_of = 2'd1;
        else if (cnt <= e2) phase_of = 2'd2;
        else                phase_of = 2'd3;
    endfunction

    // Sequencing: next divider/counter values and the pulses that accompany them.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        pix_tick_d    = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                hcnt_d = '0;
                vcnt_d = '0;
                if (EN) begin
                    // The start edge is itself the first pixel tick of a fresh frame.
                    state_d       = ST_RUN;
                    pix_tick_d    = 1'b1;
                    line_start_d  = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    pix_tick_d = 1'b1;
                    if (hcnt_q == H_LAST) begin
                        hcnt_d       = '0;
                        line_start_d = 1'b1;
                        if (vcnt_q == V_LAST) begin
                            vcnt_d = '0;
                            // EN only matters here, so a stop never truncates a frame.
                            if (EN) frame_start_d = 1'b1;
                            else    state_d       = ST_IDLE;
                        end else begin
                            vcnt_d = vcnt_q + 10'd1;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 10'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            div_d        = '0;
            hcnt_d       = '0;
            vcnt_d       = '0;
            pix_tick_d   = 1'b0;
            line_start_d = 1'b0;
        end
    end

    // Decode from the next counter values so every output lines up with HCNT/VCNT.
    always_comb begin
        running_d = (state_d == ST_RUN);
        h_state_d = running_d ? phase_of(hcnt_d, H_S0, H_S1, H_S2) : 2'd0;
        v_state_d = running_d ? phase_of(vcnt_d, V_S0, V_S1, V_S2) : 2'd0;
        hs_d      = !running_d || (h_state_d != 2'd0);
        vs_d      = !running_d || (v_state_d != 2'd0);
        active_d  = running_d && (h_state_d == 2'd2) && (v_state_d == 2'd2);
        x_d       = active_d ? (hcnt_d - X_ORG) : 10'd0;
        y_d       = active_d ? (vcnt_d - Y_ORG) : 10'd0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_state_q     <= 2'd0;
            v_state_q     <= 2'd0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_tick_q    <= pix_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign PIX_TICK    = pix_tick_q;
    assign HCNT        = hcnt_q;
    assign VCNT        = vcnt_q;
    assign H_STATE     = h_state_q;
    assign V_STATE     = v_state_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign ACTIVE      = active_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign RUNNING     = running_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller on a shrunken raster (16x10 pixels), one instance
// with PIX_DIV=2 and one with PIX_DIV=1, against a frame-position reference model.
module tb_vga_scan_controller;

    localparam int HSE = 3, HBE = 5, HAE = 13, HT = 16;
    localparam int VSE = 1, VBE = 3, VAE = 8,  VT = 10;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic EN = 1'b0;

    always #5 CLK = ~CLK;

    logic       tick2, hs2, vs2, act2, ls2, fs2, run2;
    logic [9:0] h2, v2, x2, y2;
    logic [1:0] hst2, vst2;
    logic       tick1, hs1, vs1, act1, ls1, fs1, run1;
    logic [9:0] h1, v1, x1, y1;
    logic [1:0] hst1, vst1;

    vga_scan_controller #(.PIX_DIV(2), .H_SYNC_END(HSE), .H_BP_END(HBE), .H_ACT_END(HAE),
        .H_TOTAL(HT), .V_SYNC_END(VSE), .V_BP_END(VBE), .V_ACT_END(VAE), .V_TOTAL(VT)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .PIX_TICK(tick2), .HCNT(h2), .VCNT(v2),
        .H_STATE(hst2), .V_STATE(vst2), .HS(hs2), .VS(vs2), .ACTIVE(act2), .X(x2), .Y(y2),
        .LINE_START(ls2), .FRAME_START(fs2), .RUNNING(run2));

    vga_scan_controller #(.PIX_DIV(1), .H_SYNC_END(HSE), .H_BP_END(HBE), .H_ACT_END(HAE),
        .H_TOTAL(HT), .V_SYNC_END(VSE), .V_BP_END(VBE), .V_ACT_END(VAE), .V_TOTAL(VT)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .PIX_TICK(tick1), .HCNT(h1), .VCNT(v1),
        .H_STATE(hst1), .V_STATE(vst1), .HS(hs1), .VS(vs1), .ACTIVE(act1), .X(x1), .Y(y1),
        .LINE_START(ls1), .FRAME_START(fs1), .RUNNING(run1));

    // Model: just "running" and k = CLKs elapsed since the current frame began.
    typedef struct {
        bit running;
        int k;
    } mdl_t;

    typedef struct {
        bit rst_n;
        bit en;
        int ncyc;
        bit running;
        int h;
        int v;
        bit fs;
        bit ls;
        bit tick;
    } vec_t;

    mdl_t m2, m1;
    int   total = 0;
    int   bad   = 0;

    function automatic mdl_t mstep(mdl_t m, bit rst_n, bit en, int div);
        mdl_t r = m;
        if (!rst_n) begin
            r.running = 0; r.k = 0;
        end else if (!m.running) begin
            if (en) begin r.running = 1; r.k = 0; end
        end else begin
            r.k = m.k + 1;
            if (r.k == HT * VT * div) begin
                r.k = 0;
                if (!en) r.running = 0;
            end
        end
        return r;
    endfunction

    function automatic int phase(int c, int e0, int e1, int e2);
        if (c <= e0) return 0;
        if (c <= e1) return 1;
        if (c <= e2) return 2;
        return 3;
    endfunction

    // Bundle layout: {RUNNING,PIX_TICK,LINE_START,FRAME_START,HS,VS,ACTIVE,H_ST,V_ST,H,V,X,Y}
    function automatic logic [50:0] mexp(mdl_t m, int div);
        int p, h, v, hp, vp;
        bit tk, act;
        logic [9:0] x, y;
        if (!m.running) return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 40'd0};
        p   = m.k / div;
        tk  = (m.k % div) == 0;
        h   = p % HT;
        v   = p / HT;
        hp  = phase(h, HSE, HBE, HAE);
        vp  = phase(v, VSE, VBE, VAE);
        act = (hp == 2) && (vp == 2);
        x   = act ? 10'(h - (HBE + 1)) : 10'd0;
        y   = act ? 10'(v - (VBE + 1)) : 10'd0;
        return {1'b1, tk, tk && (h == 0), m.k == 0, hp != 0, vp != 0, act,
                2'(hp), 2'(vp), 10'(h), 10'(v), x, y};
    endfunction

    task automatic chk(input string name, input logic [50:0] act, input logic [50:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        m2 = mstep(m2, RST_N, EN, 2);
        m1 = mstep(m1, RST_N, EN, 1);
        @(negedge CLK);
        chk("div2_all", {run2, tick2, ls2, fs2, hs2, vs2, act2, hst2, vst2, h2, v2, x2, y2}, mexp(m2, 2));
        chk("div1_all", {run1, tick1, ls1, fs1, hs1, vs1, act1, hst1, vst1, h1, v1, x1, y1}, mexp(m1, 1));
    endtask

    vec_t tbl[$];
    int   gap;
    bit   seen;

    initial begin
        m2 = '{running: 0, k: 0};
        m1 = '{running: 0, k: 0};

        // Hand-derived for PIX_DIV=2: frame = 320 CLKs, line = 32 CLKs.
        tbl.push_back('{0, 0, 1,   0, 0, 0, 0, 0, 0});  // reset state
        tbl.push_back('{1, 1, 1,   1, 0, 0, 1, 1, 1});  // start edge
        tbl.push_back('{1, 1, 1,   1, 0, 0, 0, 0, 0});  // k=1, no tick
        tbl.push_back('{1, 0, 1,   1, 1, 0, 0, 0, 1});  // EN drop mid-frame ignored
        tbl.push_back('{1, 0, 29,  1, 15, 0, 0, 0, 0}); // k=31, end of line 0
        tbl.push_back('{1, 0, 1,   1, 0, 1, 0, 1, 1});  // line wrap
        tbl.push_back('{1, 0, 287, 1, 15, 9, 0, 0, 0}); // k=319, last pixel
        tbl.push_back('{1, 0, 1,   0, 0, 0, 0, 0, 0});  // wrap with EN=0 -> idle
        tbl.push_back('{1, 0, 3,   0, 0, 0, 0, 0, 0});  // idle holds
        tbl.push_back('{1, 1, 1,   1, 0, 0, 1, 1, 1});  // restart
        tbl.push_back('{1, 1, 319, 1, 15, 9, 0, 0, 0});
        tbl.push_back('{1, 1, 1,   1, 0, 0, 1, 1, 1});  // wrap with EN=1 continues
        tbl.push_back('{1, 1, 100, 1, 2, 3, 0, 0, 1});  // mid-frame
        tbl.push_back('{0, 1, 1,   0, 0, 0, 0, 0, 0});  // reset mid-frame
        tbl.push_back('{1, 1, 1,   1, 0, 0, 1, 1, 1});  // run again after release

        foreach (tbl[i]) begin
            RST_N = tbl[i].rst_n;
            EN    = tbl[i].en;
            repeat (tbl[i].ncyc) cycle();
            chk($sformatf("vec%0d", i),
                {7'b0, run2, h2, v2, fs2, ls2, tick2, 22'b0},
                {7'b0, tbl[i].running, 10'(tbl[i].h), 10'(tbl[i].v),
                 tbl[i].fs, tbl[i].ls, tbl[i].tick, 22'b0});
        end

        // First active pixel at H=6, V=4 -> k=140.
        repeat (140) cycle();
        chk("first_active", {41'b0, act2, x2, hs2, vs2, 4'b0},
            {41'b0, 1'b1, 10'd0, 1'b1, 1'b1, 4'b0});
        chk("first_active_y", {41'b0, y2}, {41'b0, 10'd0});
        // Last active pixel H=13, V=8 -> k=282.
        repeat (142) cycle();
        chk("last_active", {31'b0, act2, x2, y2}, {31'b0, 1'b1, 10'd7, 10'd4});
        repeat (2) cycle();
        chk("front_porch", {31'b0, act2, x2, y2, hst2}, {29'b0, 1'b0, 10'd0, 10'd0, 2'd3});

        // LINE_START spacing: one line of 16 pixels at 2 CLKs each.
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin cycle(); seen = ls2; end
        chk("ls_found", {50'b0, seen}, {50'b0, 1'b1});
        gap = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin cycle(); gap++; seen = ls2; end
        chk("ls_gap", {19'b0, 32'(gap)}, {19'b0, 32'd32});

        // Random EN/reset traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) EN = ~EN;
            RST_N = ($urandom_range(499) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Master timing sequencer for the VGA display path. It divides CLK into a pixel tick, runs the horizontal (0..799) and vertical (0..524) scan counters, and drives the 4-state horizontal and vertical phase codes, HS/VS, active-video, and pixel coordinates. It also handles frame-aligned start/stop so downstream pixel logic never sees a partial frame.

Parameters:
PIX_DIV, 2, CLK cycles per pixel tick (50 MHz CLK -> 25 MHz pixels); legal range >=1
H_SYNC_END, 95, last HCNT of the H sync pulse (state S0)
H_BP_END, 143, last HCNT of the H back porch (S1)
H_ACT_END, 783, last HCNT of active video (S2)
H_TOTAL, 800, HCNT wraps from H_TOTAL-1 to 0 (S3 = front porch)
V_SYNC_END, 1, last VCNT of the V sync pulse (S0)
V_BP_END, 34, last VCNT of the V back porch (S1)
V_ACT_END, 514, last VCNT of active video (S2)
V_TOTAL, 525, VCNT wraps from V_TOTAL-1 to 0 (S3 = front porch)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  synchronous, active-low reset
EN  in  1  run request; sampled every CLK
PIX_TICK  out  1  one-CLK pulse on each pixel advance
HCNT  out  10  horizontal count
VCNT  out  10  vertical count
H_STATE  out  2  0 sync, 1 back porch, 2 active, 3 front porch
V_STATE  out  2  same encoding for vertical
HS  out  1  horizontal sync, low in H_STATE 0
VS  out  1  vertical sync, low in V_STATE 0
ACTIVE  out  1  high when H_STATE==2 and V_STATE==2
X  out  10  HCNT-(H_BP_END+1) when ACTIVE, else 0
Y  out  10  VCNT-(V_BP_END+1) when ACTIVE, else 0
LINE_START  out  1  one-CLK pulse when HCNT becomes 0
FRAME_START  out  1  one-CLK pulse when HCNT and VCNT both become 0
RUNNING  out  1  high in RUN state

Behaviour:
- One clock (CLK); reset is synchronous and active-low (RST_N). All outputs are registered.
- Reset (RST_N==0 at an edge) forces IDLE from that edge: divider=0, HCNT=VCNT=0, H_STATE=V_STATE=0, HS=VS=1, ACTIVE=0, X=Y=0, all pulses 0, RUNNING=0. Reset mid-frame aborts immediately with no wind-down.
- Control FSM has two states:
  - IDLE: counters held at 0, HS=VS=1, ACTIVE=0. If EN=1, the next edge goes to RUN with divider=0, HCNT=VCNT=0, H_STATE=V_STATE=0, HS=VS=0, RUNNING=1, and pulses LINE_START and FRAME_START. That edge counts as the first pixel tick.
  - RUN: the divider counts 0..PIX_DIV-1. PIX_TICK=1 on the edge where the divider wraps to 0. Counters advance only on tick edges.
- Counter advance on a tick: HCNT+1. At H_TOTAL-1, HCNT goes to 0, VCNT+1, and LINE_START pulses. At VCNT V_TOTAL-1 with the H wrap, VCNT goes to 0 and FRAME_START pulses.
- State, sync and coordinate outputs are decoded from the new counter values and registered on the same edge. There is zero lag between HCNT/VCNT and H_STATE/V_STATE/HS/VS/ACTIVE/X/Y.
- Phase decode, horizontal: S0 for HCNT<=H_SYNC_END, S1 for <=H_BP_END, S2 for <=H_ACT_END, otherwise S3. Vertical uses the same rule with the V_* parameters.
- Stop: EN is evaluated only at the frame-wrap tick, i.e. the tick where HCNT=H_TOTAL-1 and VCNT=V_TOTAL-1.
  - EN=0 there: transition to IDLE with IDLE output values; no FRAME_START.
  - EN=1 there: continue into the next frame.
  - EN toggling mid-frame has no effect.
- With PIX_DIV=1, PIX_TICK stays high continuously in RUN.
- Nominal frame length: H_TOTAL*V_TOTAL*PIX_DIV = 840000 CLK cycles.

Test Plan:
- Reset, then EN=1 -> one edge later RUNNING=1, FRAME_START=LINE_START=1 for one CLK, HCNT=VCNT=0, HS=VS=0; PIX_TICK on every second CLK thereafter.
- Run one full line -> HS low for HCNT 0..95; H_STATE goes 1 at 96, 2 at 144, 3 at 784; second LINE_START exactly 1600 CLKs after the first.
- Run to VCNT=35, HCNT=144 -> ACTIVE=1, X=0, Y=0; at HCNT=783, VCNT=514: X=639, Y=479; at HCNT=784, ACTIVE=0 and X=Y=0.
- Continuous EN=1 -> FRAME_START pulses every 840000 CLKs; VS low only for VCNT 0..1; V_STATE goes 1 at 2, 2 at 35, 3 at 515.
- Drop EN at VCNT=200 -> frame completes; at the wrap tick go to IDLE, RUNNING=0, HS=VS=1, no FRAME_START. Re-raise EN -> restart with FRAME_START one edge later.
- Assert RST_N=0 at VCNT=300 for one CLK -> next edge shows all reset values; EN held high -> RUN again one edge after reset releases.
